// File: rtl/lcd_bus_monitor.sv
// Passive HD44780-style character-LCD bus receiver that keeps a 2x16 shadow of the display RAM.
// States: S_IDLE | decode strobes ; S_CLEAR | fill buffer with CLEAR_CHAR, one entry per cycle
module lcd_bus_monitor #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  CLEAR_CHAR  = 8'h20,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             LCD_ON,
    input  logic             LCD_RS,
    input  logic             LCD_EN,
    input  logic             LCD_RW,
    input  logic [7:0]       LCD_DATA,
    input  logic [4:0]       rd_addr,
    output logic [7:0]       rd_char,
    output logic [4:0]       cursor,
    output logic             display_on,
    output logic             inc_mode,
    output logic             busy,
    output logic             overrun,
    output logic             bad_cmd,
    output logic [CNT_W-1:0] write_count
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam int BUS_W = 12;

    logic [BUS_W-1:0] bus_pin;
    logic [BUS_W-1:0] sync_q [SYNC_STAGES];
    logic [BUS_W-1:0] bus_s;
    logic             on_s, rw_s, rs_s, en_s;
    logic [7:0]       data_s;
    logic             en_prev_q;
    logic             stb_d;
    logic             stb_q;
    logic             stb_rs_q;
    logic [7:0]       stb_data_q;

    state_t           state_q;
    logic [4:0]       fill_q;
    logic [4:0]       cursor_q;
    logic             disp_q;
    logic             inc_q;
    logic             busy_q;
    logic             ovr_q;
    logic             bad_q;
    logic             cgram_q;
    logic [CNT_W-1:0] wcnt_q;

    logic [7:0]       mem_q [32];
    logic [7:0]       rd_char_q;
    logic             we;
    logic [4:0]       waddr;
    logic [7:0]       wdata;
    logic [6:0]       ddram_a;

    assign bus_pin = {LCD_ON, LCD_RW, LCD_RS, LCD_EN, LCD_DATA};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus_pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign bus_s  = sync_q[SYNC_STAGES-1];
    assign on_s   = bus_s[11];
    assign rw_s   = bus_s[10];
    assign rs_s   = bus_s[9];
    assign en_s   = bus_s[8];
    assign data_s = bus_s[7:0];

    // RS and DATA come from the same stage as the EN fall, so they are the values held at the strobe
    assign stb_d = en_prev_q & ~en_s & ~rw_s & on_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_prev_q  <= 1'b0;
            stb_q      <= 1'b0;
            stb_rs_q   <= 1'b0;
            stb_data_q <= 8'h00;
        end else begin
            en_prev_q  <= en_s;
            stb_q      <= stb_d;
            stb_rs_q   <= rs_s;
            stb_data_q <= data_s;
        end
    end

    assign ddram_a = stb_data_q[6:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_CLEAR;
            fill_q   <= 5'd0;
            cursor_q <= 5'd0;
            disp_q   <= 1'b0;
            inc_q    <= 1'b1;
            busy_q   <= 1'b1;
            ovr_q    <= 1'b0;
            bad_q    <= 1'b0;
            cgram_q  <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    fill_q <= fill_q + 5'd1;
                    if (fill_q == 5'd31) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    if (stb_q) begin
                        ovr_q <= 1'b1;
                    end
                end
                default: begin
                    if (stb_q && stb_rs_q) begin
                        // CGRAM pattern writes are not mirrored and do not move the cursor
                        if (!cgram_q) begin
                            cursor_q <= inc_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
                            if (wcnt_q != '1) begin
                                wcnt_q <= wcnt_q + CNT_W'(1);
                            end
                        end
                    end else if (stb_q) begin
                        casez (stb_data_q)
                            8'b1???????: begin
                                cgram_q <= 1'b0;
                                if (ddram_a[6:4] == 3'b000) begin
                                    cursor_q <= {1'b0, ddram_a[3:0]};
                                end else if (ddram_a[6:4] == 3'b100) begin
                                    cursor_q <= {1'b1, ddram_a[3:0]};
                                end else begin
                                    bad_q <= 1'b1;
                                end
                            end
                            8'b01??????: begin
                                cgram_q <= 1'b1;
                            end
                            8'b001?????: begin
                            end
                            8'b0001????: begin
                                if (stb_data_q[3]) begin
                                    bad_q <= 1'b1;
                                end else begin
                                    cursor_q <= stb_data_q[2] ? cursor_q + 5'd1 : cursor_q - 5'd1;
                                end
                            end
                            8'b00001???: begin
                                disp_q <= stb_data_q[2];
                            end
                            8'b000001??: begin
                                inc_q <= stb_data_q[1];
                                if (stb_data_q[0]) begin
                                    bad_q <= 1'b1;
                                end
                            end
                            8'b0000001?: begin
                                cursor_q <= 5'd0;
                            end
                            8'b00000001: begin
                                state_q  <= S_CLEAR;
                                busy_q   <= 1'b1;
                                fill_q   <= 5'd0;
                                cursor_q <= 5'd0;
                                inc_q    <= 1'b1;
                                cgram_q  <= 1'b0;
                            end
                            default: begin
                                bad_q <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        we    = 1'b0;
        waddr = cursor_q;
        wdata = stb_data_q;
        if (state_q == S_CLEAR) begin
            we    = 1'b1;
            waddr = fill_q;
            wdata = CLEAR_CHAR;
        end else if (stb_q && stb_rs_q && !cgram_q) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read sees the pre-write contents when it collides with a write to the same index
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_char_q <= 8'h00;
        end else begin
            rd_char_q <= mem_q[rd_addr];
        end
    end

    assign rd_char     = rd_char_q;
    assign cursor      = cursor_q;
    assign display_on  = disp_q;
    assign inc_mode    = inc_q;
    assign busy        = busy_q;
    assign overrun     = ovr_q;
    assign bad_cmd     = bad_q;
    assign write_count = wcnt_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_lcd_bus_monitor;

    localparam int K_RD     = 0;
    localparam int K_CUR    = 1;
    localparam int K_WC     = 2;
    localparam int K_BAD    = 3;
    localparam int K_OVR    = 4;
    localparam int K_BUSY   = 5;
    localparam int K_DISP   = 6;
    localparam int K_INC    = 7;
    localparam int K_BLEN   = 8;
    localparam int K_QEMPTY = 9;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        logic [4:0]  addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        LCD_ON, LCD_RS, LCD_EN, LCD_RW;
    logic [7:0]  LCD_DATA;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_char;
    logic [4:0]  cursor;
    logic        display_on, inc_mode, busy, overrun, bad_cmd;
    logic [15:0] write_count;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          busy_len = 0;
    logic        tb_req = 1'b0;
    logic        mon_req = 1'b0;

    always #5 clk = ~clk;

    lcd_bus_monitor #(
        .SYNC_STAGES(2),
        .CLEAR_CHAR (8'h20),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .LCD_ON     (LCD_ON),
        .LCD_RS     (LCD_RS),
        .LCD_EN     (LCD_EN),
        .LCD_RW     (LCD_RW),
        .LCD_DATA   (LCD_DATA),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .cursor     (cursor),
        .display_on (display_on),
        .inc_mode   (inc_mode),
        .busy       (busy),
        .overrun    (overrun),
        .bad_cmd    (bad_cmd),
        .write_count(write_count)
    );

    function automatic string kname(input int k);
        case (k)
            K_RD:     return "rd_char";
            K_CUR:    return "cursor";
            K_WC:     return "write_count";
            K_BAD:    return "bad_cmd";
            K_OVR:    return "overrun";
            K_BUSY:   return "busy";
            K_DISP:   return "display_on";
            K_INC:    return "inc_mode";
            K_BLEN:   return "busy_cycles";
            K_QEMPTY: return "queue_left";
            default:  return "unknown";
        endcase
    endfunction

    always @(posedge clk) mon_req <= tb_req;

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        if (mon_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: response requested with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_RD:     act = {8'h00, rd_char};
                    K_CUR:    act = {11'h000, cursor};
                    K_WC:     act = write_count;
                    K_BAD:    act = {15'h0000, bad_cmd};
                    K_OVR:    act = {15'h0000, overrun};
                    K_BUSY:   act = {15'h0000, busy};
                    K_DISP:   act = {15'h0000, display_on};
                    K_INC:    act = {15'h0000, inc_mode};
                    K_BLEN:   act = busy_len[15:0];
                    K_QEMPTY: act = 16'(exp_q.size());
                    default:  act = 16'hxxxx;
                endcase
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s (addr %0d): got %0h expected %0h", kname(e.kind), e.addr, act, e.exp);
                end
            end
        end
    end

    task automatic chk(input int kind, input logic [15:0] exp, input logic [4:0] addr = 5'd0);
        exp_t e;
        @(negedge clk);
        e.kind = kind;
        e.exp  = exp;
        e.addr = addr;
        rd_addr = addr;
        exp_q.push_back(e);
        tb_req = 1'b1;
        @(negedge clk);
        tb_req = 1'b0;
    endtask

    task automatic lcd(input logic rs, input logic [7:0] d, input logic rw = 1'b0,
                       input logic on = 1'b1, input int post = 8);
        @(negedge clk);
        LCD_ON   = on;
        LCD_RW   = rw;
        LCD_RS   = rs;
        LCD_DATA = d;
        LCD_EN   = 1'b1;
        repeat (3) @(negedge clk);
        LCD_EN = 1'b0;
        repeat (post) @(negedge clk);
        LCD_ON = 1'b1;
        LCD_RW = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        resetn   = 1'b0;
        LCD_ON   = 1'b1;
        LCD_RS   = 1'b0;
        LCD_EN   = 1'b0;
        LCD_RW   = 1'b0;
        LCD_DATA = 8'h00;
        rd_addr  = 5'd0;

        chk(K_BUSY, 16'd1);
        chk(K_CUR,  16'd0);
        chk(K_INC,  16'd1);
        chk(K_DISP, 16'd0);
        chk(K_WC,   16'd0);
        chk(K_OVR,  16'd0);
        chk(K_RD,   16'h00, 5'd5);

        @(negedge clk);
        resetn = 1'b1;
        busy_len = 0;
        while (busy && busy_len < 100) begin
            busy_len++;
            @(negedge clk);
        end
        chk(K_BLEN, 16'd32);
        for (int i = 0; i < 32; i++) chk(K_RD, 16'h20, 5'(i));
        chk(K_CUR, 16'd0);
        chk(K_WC,  16'd0);
        chk(K_BAD, 16'd0);

        lcd(1'b0, 8'h80);
        lcd(1'b1, 8'h48);
        lcd(1'b1, 8'h49);
        chk(K_RD,  16'h48, 5'd0);
        chk(K_RD,  16'h49, 5'd1);
        chk(K_CUR, 16'd2);
        chk(K_WC,  16'd2);

        lcd(1'b0, 8'hC5);
        chk(K_CUR, 16'd21);
        lcd(1'b1, 8'h41);
        chk(K_RD,  16'h41, 5'd21);
        chk(K_CUR, 16'd22);
        chk(K_WC,  16'd3);
        chk(K_BAD, 16'd0);
        lcd(1'b0, 8'h90);
        chk(K_BAD, 16'd1);
        chk(K_CUR, 16'd22);

        lcd(1'b0, 8'h04);
        chk(K_INC, 16'd0);
        lcd(1'b0, 8'h80);
        lcd(1'b1, 8'h5A);
        chk(K_RD,  16'h5A, 5'd0);
        chk(K_CUR, 16'd31);
        chk(K_WC,  16'd4);
        lcd(1'b0, 8'h06);
        chk(K_INC, 16'd1);
        lcd(1'b0, 8'hCF);
        chk(K_CUR, 16'd31);
        lcd(1'b1, 8'h31);
        chk(K_RD,  16'h31, 5'd31);
        chk(K_CUR, 16'd0);
        chk(K_WC,  16'd5);
        chk(K_RD,  16'h49, 5'd1);

        lcd(1'b0, 8'h0C);
        chk(K_DISP, 16'd1);
        lcd(1'b0, 8'h14);
        chk(K_CUR, 16'd1);
        lcd(1'b0, 8'h10);
        lcd(1'b0, 8'h10);
        chk(K_CUR, 16'd31);
        lcd(1'b0, 8'h08);
        chk(K_DISP, 16'd0);

        lcd(1'b0, 8'h04);
        lcd(1'b0, 8'h01, 1'b0, 1'b1, 5);
        lcd(1'b1, 8'h55);
        repeat (40) @(negedge clk);
        chk(K_OVR,  16'd1);
        chk(K_BUSY, 16'd0);
        chk(K_CUR,  16'd0);
        chk(K_INC,  16'd1);
        chk(K_WC,   16'd5);
        chk(K_BAD,  16'd1);
        chk(K_RD,   16'h20, 5'd0);
        chk(K_RD,   16'h20, 5'd1);
        chk(K_RD,   16'h20, 5'd21);
        chk(K_RD,   16'h20, 5'd31);

        lcd(1'b0, 8'h40);
        lcd(1'b1, 8'h1F);
        lcd(1'b1, 8'h1F);
        lcd(1'b1, 8'h1F);
        chk(K_CUR, 16'd0);
        chk(K_WC,  16'd5);
        lcd(1'b0, 8'h80);
        chk(K_RD,  16'h20, 5'd0);
        chk(K_RD,  16'h20, 5'd1);
        chk(K_RD,  16'h20, 5'd2);
        chk(K_WC,  16'd5);

        lcd(1'b1, 8'h41, 1'b1, 1'b1);
        lcd(1'b1, 8'h41, 1'b0, 1'b0);
        lcd(1'b0, 8'hC3, 1'b1, 1'b1);
        chk(K_RD,  16'h20, 5'd0);
        chk(K_CUR, 16'd0);
        chk(K_WC,  16'd5);

        lcd(1'b1, 8'h42);
        chk(K_RD,  16'h42, 5'd0);
        chk(K_CUR, 16'd1);
        chk(K_WC,  16'd6);

        chk(K_QEMPTY, 16'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_monitor.md
Name: lcd_bus_monitor

Overview:
- Passive receiver for the character-LCD parallel bus (LCD_ON, LCD_RS, LCD_EN, LCD_RW, LCD_DATA) that the LCD controller drives.
- Decodes HD44780-style command and data writes into a 32-character shadow display buffer: 2 rows x 16 columns.
- Exposes the buffer through a registered read port, with cursor and status outputs.
- Sits beside the LCD path for on-board debug (mirror to 7-seg/UART) and as the checking end in controller benches.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on every LCD bus input; legal values 2 or 3.
- CLEAR_CHAR, 8'h20, fill character written by clear and reset.
- CNT_W, 16, width of the saturating write counter.

Ports:
- clk  input  1  system clock; asynchronous to the LCD bus.
- resetn  input  1  asynchronous reset, active-low.
- LCD_ON  input  1  panel power; bus ignored while 0.
- LCD_RS  input  1  0 = command, 1 = data.
- LCD_EN  input  1  enable strobe; transfer captured on its falling edge.
- LCD_RW  input  1  1 = read cycle.
- LCD_DATA  input  8  bus data.
- rd_addr  input  5  buffer index 0-15 = row 0, 16-31 = row 1.
- rd_char  output  8  buffer[rd_addr], registered, 1-cycle latency.
- cursor  output  5  current buffer index.
- display_on  output  1  D bit from the last display-control command.
- inc_mode  output  1  I/D bit from the last entry-mode command.
- busy  output  1  high while in CLEAR.
- overrun  output  1  sticky; a strobe arrived while busy.
- bad_cmd  output  1  sticky; unsupported command or illegal DDRAM address.
- write_count  output  CNT_W  data writes accepted; saturates at all-ones.

Behaviour:
- Input capture:
  - All five bus inputs pass through SYNC_STAGES flops, then one more flop for edge detect.
  - Strobe = synchronized EN 1 -> 0 with RW = 0 and ON = 1. Data and RS are sampled from the same synchronized stage.
  - The strobe's effect is visible on outputs SYNC_STAGES+2 clk cycles after the EN falling edge at the pin.
  - Strobes with RW = 1 or ON = 0 are ignored silently.
- State machine has two states, IDLE and CLEAR.
- Reset:
  - resetn = 0 forces CLEAR with its fill index at 0.
  - cursor = 0, display_on = 0, inc_mode = 1, overrun = 0, bad_cmd = 0, write_count = 0, rd_char = 0.
  - busy = 1 during reset and the following CLEAR.
- CLEAR state:
  - Writes CLEAR_CHAR to one entry per cycle, indices 0..31.
  - Returns to IDLE after index 31; busy is high for exactly 32 cycles.
  - Any strobe during CLEAR is dropped and sets overrun.
  - Reset asserted mid-CLEAR restarts the fill at index 0.
- Command decode (RS = 0), by highest set bit of DATA:
  - 8'h01 (clear display): enter CLEAR; cursor = 0; inc_mode = 1.
  - 8'h02-03 (return home): cursor = 0.
  - 8'h04-07 (entry mode): inc_mode = D[1]. D[0] = 1 (display shift) is unsupported: sets bad_cmd, otherwise applied.
  - 8'h08-0F (display control): display_on = D[2].
  - 8'h10-1F (cursor/display shift): if D[3] = 0, cursor moves +1 when D[2] = 1, else -1, with wrap. If D[3] = 1, sets bad_cmd, no change.
  - 8'h20-3F (function set): accepted, no effect.
  - 8'h40-7F (CGRAM address): enters CGRAM mode; following data writes are discarded and not counted until the next DDRAM-address or clear command.
  - 8'h80-FF (DDRAM address): address A = D[6:0].
    - A 0x00-0x0F -> cursor = A.
    - A 0x40-0x4F -> cursor = 16 + A[3:0].
    - Any other A -> bad_cmd set, cursor unchanged.
    - Also exits CGRAM mode.
  - 8'h00: sets bad_cmd.
- Data write (RS = 1, not CGRAM mode):
  - buffer[cursor] = DATA.
  - Then cursor = cursor+1 if inc_mode, else cursor-1, modulo 32 (31 -> 0, 0 -> 31).
  - write_count += 1 unless already all-ones.
- Read port:
  - rd_char updates every cycle from rd_addr.
  - If a write and a read target the same index in the same cycle, rd_char returns the old value; the new value is available the next cycle.
- At most one strobe is processed per cycle; a new strobe can only arrive every 2+ cycles after synchronization.
- overrun and bad_cmd clear only on reset.

Test Plan:
- Reset release -> busy high exactly 32 cycles; afterwards, reading all 32 indices returns 8'h20; cursor = 0, write_count = 0.
- Send cmd 8'h80, data "HI" (8'h48, 8'h49) -> rd_addr 0 = 8'h48, rd_addr 1 = 8'h49, cursor = 2, write_count = 2.
- Send cmd 8'hC5, data 8'h41 -> buffer[21] = 8'h41, cursor = 22. Then cmd 8'h90 -> bad_cmd = 1, cursor stays 22.
- Send cmd 8'h04 (decrement), cmd 8'h80, data 8'h5A -> buffer[0] = 8'h5A, cursor = 31. Then cmd 8'h06, cmd 8'hCF, data 8'h31 -> buffer[31] = 8'h31, cursor wraps to 0.
- Send cmd 8'h01, then a data strobe 5 cycles later -> strobe dropped, overrun = 1, buffer all 8'h20 after 32 busy cycles, write_count unchanged.
- Send cmd 8'h40, data 8'h1F x3, cmd 8'h80 -> buffer unchanged and write_count unchanged. A read strobe (RW = 1) or a strobe with LCD_ON = 0 -> no state change.
